stack_mem_resp: RTL and testbench

Memory-side responder for stack traffic issued by the stack-pointer controller. Accepts one PUSH/POP/CALL/RET request at a time over a valid/ready handshake and performs the word access into a private stack RAM. Tracks occupancy and per-entry frame type (data vs. return address), and returns read data plus an error code over a second valid/ready handshake. Sits between the stack-pointer controller and the datapath's LMD/PC-update logic.

---
 rtl/stack_mem_resp.sv | 132 +++++++++++++
 tb/tb_stack_mem_resp.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_resp.sv
// Stack RAM responder: one PUSH/POP/CALL/RET at a time, with occupancy and
// per-entry frame-type tracking, answering over a valid/ready response channel.
module stack_mem_resp #(
    parameter logic [31:0] BASE  = 32'hFFFF_FFC0,
    parameter int          DEPTH = 64,
    parameter int          AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic [2:0]    rsp_err,
    output logic [AW:0]   count
);
    // state    | meaning
    // S_IDLE   | waiting for a request, req_ready high
    // S_ACCESS | classify latched request, do the RAM access, update count/tags
    // S_RESP   | response held on the output until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    localparam logic [2:0] E_OK   = 3'b000;
    localparam logic [2:0] E_OVF  = 3'b001;
    localparam logic [2:0] E_UNF  = 3'b010;
    localparam logic [2:0] E_RNG  = 3'b011;
    localparam logic [2:0] E_ILL  = 3'b100;
    localparam logic [2:0] E_MISM = 3'b101;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic [DEPTH-1:0]  tag;
    logic              rd_en;

    logic [31:0]       off;
    logic [AW-1:0]     idx;
    logic              in_range, is_wr, is_rd;
    logic [2:0]        err_c;
    logic              do_wr, do_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_ACCESS;
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (state == S_IDLE && req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Offset is unsigned, so addresses below BASE wrap high and fail the range test.
    always_comb begin
        off      = addr_q - BASE;
        idx      = off[AW-1:0];
        in_range = off < 32'(DEPTH);
        is_wr    = (op_q == OP_PUSH) || (op_q == OP_CALL);
        is_rd    = (op_q == OP_POP)  || (op_q == OP_RET);
        if (!(is_wr || is_rd))                         err_c = E_ILL;
        else if (!in_range)                            err_c = E_RNG;
        else if (is_wr && count == FULL)               err_c = E_OVF;
        else if (is_rd && count == '0)                 err_c = E_UNF;
        else if (is_rd && (tag[idx] != (op_q == OP_RET))) err_c = E_MISM;
        else                                           err_c = E_OK;
        do_wr = (state == S_ACCESS) && is_wr && (err_c == E_OK);
        do_rd = (state == S_ACCESS) && is_rd && (err_c == E_OK || err_c == E_MISM);
    end

    // RAM has no reset; reset forces state to IDLE so no write slips through.
    always_ff @(posedge clk) begin
        if (do_wr) mem[idx] <= wdata_q;
        if (state == S_ACCESS) ram_q <= mem[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            tag     <= '0;
            rsp_err <= E_OK;
            rd_en   <= 1'b0;
        end else if (state == S_ACCESS) begin
            rsp_err <= err_c;
            rd_en   <= do_rd;
            if (do_wr) begin
                count    <= count + 1'b1;
                tag[idx] <= (op_q == OP_CALL);
            end
            if (do_rd) count <= count - 1'b1;
        end
    end

    assign rsp_rdata = rd_en ? ram_q : 32'h0;
endmodule

// File: tb/tb_stack_mem_resp.sv
// Scoreboarded bench for stack_mem_resp: expected responses are queued at
// request time and compared when the response channel presents them.
module tb_stack_mem_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_op, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [6:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  err;
        logic [6:0]  cnt;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] obs_rdata;
    logic [2:0]  obs_err;
    logic [6:0]  obs_cnt;
    int          obs_lat;

    always #5 clk = ~clk;

    stack_mem_resp dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .count(count)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one request, waits (bounded) for its response, consumes it.
    task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        obs_lat = 1;
        while (!rsp_valid && obs_lat < 20) begin
            @(negedge clk);
            obs_lat++;
        end
        if (!rsp_valid) obs_lat = 99;
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        obs_cnt = count;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 3'b000) begin errors++; $display("FAIL reset_rsp_err: got %b want 000", rsp_err); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_push_pop();
        logic [2:0]  ops [2] = '{3'b001, 3'b010};
        logic [31:0] ad  [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] wd  [2] = '{32'hDEAD_BEEF, 32'h0};
        logic [31:0] rd  [2] = '{32'h0, 32'hDEAD_BEEF};
        logic [2:0]  er  [2] = '{3'b000, 3'b000};
        logic [6:0]  cn  [2] = '{7'd1, 7'd0};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_t'{rd[i], er[i], cn[i]});
            run_req(ops[i], ad[i], wd[i]);
            e = exp_q.pop_front();
            checks++; if (obs_lat !== 2) begin errors++; $display("FAIL push_pop_lat[%0d]: got %0d want 2", i, obs_lat); end
            checks++; if (obs_err !== e.err) begin errors++; $display("FAIL push_pop_err[%0d]: got %b want %b", i, obs_err, e.err); end
            checks++; if (obs_rdata !== e.rdata) begin errors++; $display("FAIL push_pop_rdata[%0d]: got %h want %h", i, obs_rdata, e.rdata); end
            checks++; if (obs_cnt !== e.cnt) begin errors++; $display("FAIL push_pop_count[%0d]: got %0d want %0d", i, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_call_ret();
        logic [2:0]  ops [4] = '{3'b011, 3'b100, 3'b011, 3'b010};
        logic [31:0] wd  [4] = '{32'h11, 32'h0, 32'h11, 32'h0};
        logic [31:0] rd  [4] = '{32'h0, 32'h11, 32'h0, 32'h11};
        logic [2:0]  er  [4] = '{3'b000, 3'b000, 3'b000, 3'b101};
        logic [6:0]  cn  [4] = '{7'd1, 7'd0, 7'd1, 7'd0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_t'{rd[i], er[i], cn[i]});
            run_req(ops[i], 32'hFFFF_FFFF, wd[i]);
            e = exp_q.pop_front();
            checks++; if (obs_err !== e.err) begin errors++; $display("FAIL call_ret_err[%0d]: got %b want %b", i, obs_err, e.err); end
            checks++; if (obs_rdata !== e.rdata) begin errors++; $display("FAIL call_ret_rdata[%0d]: got %h want %h", i, obs_rdata, e.rdata); end
            checks++; if (obs_cnt !== e.cnt) begin errors++; $display("FAIL call_ret_count[%0d]: got %0d want %0d", i, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ops [8] = '{3'b010, 3'b111, 3'b000, 3'b001, 3'b111, 3'b010, 3'b100, 3'b100};
        logic [31:0] ad  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFC0};
        logic [31:0] wd  [8] = '{32'h0, 32'h0, 32'h0, 32'h5, 32'h9, 32'h0, 32'h0, 32'h0};
        logic [31:0] rd  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'h0};
        logic [2:0]  er  [8] = '{3'b010, 3'b100, 3'b100, 3'b000, 3'b100, 3'b011, 3'b101, 3'b010};
        logic [6:0]  cn  [8] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd0, 7'd0};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exp_t'{rd[i], er[i], cn[i]});
            run_req(ops[i], ad[i], wd[i]);
            e = exp_q.pop_front();
            checks++; if (obs_err !== e.err) begin errors++; $display("FAIL errors_err[%0d]: got %b want %b", i, obs_err, e.err); end
            checks++; if (obs_rdata !== e.rdata) begin errors++; $display("FAIL errors_rdata[%0d]: got %h want %h", i, obs_rdata, e.rdata); end
            checks++; if (obs_cnt !== e.cnt) begin errors++; $display("FAIL errors_count[%0d]: got %0d want %0d", i, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_full();
        logic [2:0]  ops [4] = '{3'b001, 3'b001, 3'b010, 3'b010};
        logic [31:0] ad  [4] = '{32'hFFFF_FFBF, 32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_FFC1};
        logic [31:0] wd  [4] = '{32'h0BAD, 32'h0BAD, 32'h0, 32'h0};
        logic [31:0] rd  [4] = '{32'h0, 32'h0, 32'h103F, 32'h103E};
        logic [2:0]  er  [4] = '{3'b011, 3'b001, 3'b000, 3'b000};
        logic [6:0]  cn  [4] = '{7'd64, 7'd64, 7'd63, 7'd62};
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(exp_t'{32'h0, 3'b000, 7'(i + 1)});
            run_req(3'b001, 32'hFFFF_FFFF - 32'(i), 32'h1000 + 32'(i));
            e = exp_q.pop_front();
            checks++; if (obs_err !== e.err) begin errors++; $display("FAIL fill_err[%0d]: got %b want %b", i, obs_err, e.err); end
            checks++; if (obs_cnt !== e.cnt) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, obs_cnt, e.cnt); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_t'{rd[i], er[i], cn[i]});
            run_req(ops[i], ad[i], wd[i]);
            e = exp_q.pop_front();
            checks++; if (obs_err !== e.err) begin errors++; $display("FAIL full_err[%0d]: got %b want %b", i, obs_err, e.err); end
            checks++; if (obs_rdata !== e.rdata) begin errors++; $display("FAIL full_rdata[%0d]: got %h want %h", i, obs_rdata, e.rdata); end
            checks++; if (obs_cnt !== e.cnt) begin errors++; $display("FAIL full_count[%0d]: got %0d want %0d", i, obs_cnt, e.cnt); end
        end
        apply_reset();
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL full_reset_count: got %0d want 0", count); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        exp_q.push_back(exp_t'{32'h0, 3'b000, 7'd1});
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b001; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        req_op = 3'b010;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_seen: got %b want 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b req_ready=%b want 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready_after: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_valid_after: got %b want 0", rsp_valid); end
        checks++; if (count !== e.cnt) begin errors++; $display("FAIL bp_count: got %0d want %0d", count, e.cnt); end
        exp_q.push_back(exp_t'{32'hA5A5_A5A5, 3'b000, 7'd0});
        run_req(3'b010, 32'hFFFF_FFFF, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e.rdata) begin errors++; $display("FAIL bp_drain_rdata: got %h want %h", obs_rdata, e.rdata); end
        checks++; if (obs_cnt !== e.cnt) begin errors++; $display("FAIL bp_drain_count: got %0d want %0d", obs_cnt, e.cnt); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b001; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid: got %b want 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d responses want 0", seen); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", count); end
        exp_q.push_back(exp_t'{32'h0, 3'b010, 7'd0});
        run_req(3'b010, 32'hFFFF_FFFF, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_err !== e.err) begin errors++; $display("FAIL rmid_pop_err: got %b want %b", obs_err, e.err); end
        checks++; if (obs_rdata !== e.rdata) begin errors++; $display("FAIL rmid_pop_rdata: got %h want %h", obs_rdata, e.rdata); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_call_ret();
        test_errors();
        test_full();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
